// File: rtl/s_countdown_pkg.sv
// Shared types and defaults for the seconds countdown timer.
// Holds the FSM state encoding and the default tick divider.
package s_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_TICK_DIV = 100_000_000;
  localparam int DEF_W        = 4;

endpackage

// File: rtl/s_tick_gen.sv
// Prescaler producing a 1-cycle tick every TICK_DIV enabled cycles.
// Ports: clk, res (sync high), clear, en in; tick out (combinational).
module s_tick_gen
  import s_countdown_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic res,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Tick lands in the last count slot so the consumer acts on the wrap edge.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (res || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/s_countdown.sv
// Loadable seconds countdown: FSM, down-counter and done pulse.
// Ports: clk, res, load, load_val, start, pause in; s_num, running, done out.
module s_countdown
  import s_countdown_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int W        = DEF_W
) (
  input  logic         clk,
  input  logic         res,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         pause,
  output logic [W-1:0] s_num,
  output logic         running,
  output logic         done
);

  state_t state;
  logic   tick;
  logic   tick_en;
  logic   tick_clr;

  // Prescaler is parked at zero outside RUN/PAUSE so every fresh start
  // gets a full second; PAUSE keeps it so resume finishes the partial second.
  assign tick_en  = (state == ST_RUN);
  assign tick_clr = (state == ST_IDLE) || (state == ST_DONE) ||
                    ((state == ST_PAUSE) && load);

  s_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .res   (res),
    .clear (tick_clr),
    .en    (tick_en),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state   <= ST_IDLE;
      s_num   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (load) begin
            s_num <= load_val;
            state <= ST_IDLE;
          end else if (start) begin
            if (s_num != '0) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // A tick on the final second beats a same-cycle pause.
          if (tick && (s_num == W'(1))) begin
            s_num   <= '0;
            state   <= ST_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else begin
            if (tick) begin
              s_num <= s_num - W'(1);
            end
            if (pause) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end
          end
        end
        ST_PAUSE: begin
          if (load) begin
            s_num <= load_val;
            state <= ST_IDLE;
          end else if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_countdown.sv
// Bench for s_countdown with TICK_DIV=10: scoreboard of s_num/done events.
// No ports.
module tb_s_countdown;

  logic       clk;
  logic       res;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic       pause;
  logic [3:0] s_num;
  logic       running;
  logic       done;

  s_countdown #(
    .TICK_DIV (10),
    .W        (4)
  ) dut (
    .clk      (clk),
    .res      (res),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .s_num    (s_num),
    .running  (running),
    .done     (done)
  );

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t        snum_q[$];
  int         done_q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic       mon_en = 1'b0;
  logic [3:0] last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic pulse(input logic l, input logic [3:0] v,
                       input logic s, input logic p, output int e);
    load     = l;
    load_val = v;
    start    = s;
    pause    = p;
    e        = cyc + 1;
    @(negedge clk);
    load     = 1'b0;
    load_val = '0;
    start    = 1'b0;
    pause    = 1'b0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_s(input int c, input int v);
    ev_t ev;
    ev.cyc = c;
    ev.val = v;
    snum_q.push_back(ev);
  endtask

  // Monitor: every s_num change and every done cycle must match the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (s_num !== last) begin
        if (snum_q.size() == 0) begin
          chk("snum_unexp", int'(s_num), int'(last));
        end else begin
          ev_t ev;
          ev = snum_q.pop_front();
          chk("snum_val", int'(s_num), ev.val);
          chk("snum_cyc", cyc, ev.cyc);
        end
        last = s_num;
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("done_unexp", int'(done), 0);
        end else begin
          int dc;
          dc = done_q.pop_front();
          chk("done_cyc", cyc, dc);
        end
      end
    end
  end

  initial begin
    int e, s, r, x;
    res      = 1'b1;
    load     = 1'b1;
    load_val = 4'd9;
    start    = 1'b0;
    pause    = 1'b0;

    // 1: reset dominates a load
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_snum", int'(s_num), 0);
    chk("rst_run", int'(running), 0);
    chk("rst_done", int'(done), 0);
    res      = 1'b0;
    load     = 1'b0;
    load_val = '0;
    last     = s_num;
    mon_en   = 1'b1;

    // 2: full countdown from 5
    pulse(1'b1, 4'd5, 1'b0, 1'b0, e);
    push_s(e, 5);
    pulse(1'b0, 4'd0, 1'b1, 1'b0, s);
    for (int k = 1; k <= 5; k++) push_s(s + 10 * k, 5 - k);
    done_q.push_back(s + 50);
    chk("t2_run_on", int'(running), 1);
    wait_to(s + 49);
    chk("t2_run_mid", int'(running), 1);
    chk("t2_snum_1", int'(s_num), 1);
    wait_to(s + 50);
    chk("t2_run_off", int'(running), 0);
    chk("t2_done_hi", int'(done), 1);
    wait_to(s + 51);
    chk("t2_done_lo", int'(done), 0);

    // 3: pause mid-second, resume finishes the partial second
    pulse(1'b1, 4'd3, 1'b0, 1'b0, e);
    push_s(e, 3);
    pulse(1'b0, 4'd0, 1'b1, 1'b0, s);
    push_s(s + 10, 2);
    wait_to(s + 13);
    pulse(1'b0, 4'd0, 1'b0, 1'b1, x);
    wait_to(s + 44);
    chk("t3_paused_run", int'(running), 0);
    chk("t3_paused_snum", int'(s_num), 2);
    pulse(1'b0, 4'd0, 1'b1, 1'b0, r);
    push_s(r + 6, 1);
    push_s(r + 16, 0);
    done_q.push_back(r + 16);
    chk("t3_resume_run", int'(running), 1);
    wait_to(r + 20);

    // 4: start with zero goes straight to DONE
    pulse(1'b1, 4'd0, 1'b0, 1'b0, e);
    pulse(1'b0, 4'd0, 1'b1, 1'b0, s);
    done_q.push_back(s);
    chk("t4_done_hi", int'(done), 1);
    chk("t4_no_run", int'(running), 0);
    wait_to(s + 3);
    chk("t4_snum", int'(s_num), 0);

    // 5: reset mid-count, no done
    pulse(1'b1, 4'd7, 1'b0, 1'b0, e);
    push_s(e, 7);
    pulse(1'b0, 4'd0, 1'b1, 1'b0, s);
    push_s(s + 10, 6);
    push_s(s + 20, 5);
    wait_to(s + 24);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    push_s(s + 25, 0);
    wait_to(s + 45);
    chk("t5_run", int'(running), 0);
    chk("t5_snum", int'(s_num), 0);

    // 6: load/start ignored in RUN; load+start in IDLE only loads
    pulse(1'b1, 4'd4, 1'b0, 1'b0, e);
    push_s(e, 4);
    pulse(1'b0, 4'd0, 1'b1, 1'b0, s);
    for (int k = 1; k <= 4; k++) push_s(s + 10 * k, 4 - k);
    done_q.push_back(s + 40);
    wait_to(s + 4);
    pulse(1'b1, 4'd9, 1'b1, 1'b0, x);
    wait_to(s + 14);
    pulse(1'b0, 4'd0, 1'b1, 1'b0, x);
    wait_to(s + 20);
    chk("t6_run", int'(running), 1);
    chk("t6_snum", int'(s_num), 2);
    wait_to(s + 45);
    pulse(1'b1, 4'd2, 1'b0, 1'b0, e);
    push_s(e, 2);
    pulse(1'b1, 4'd6, 1'b1, 1'b0, e);
    push_s(e, 6);
    chk("t6_idle_run", int'(running), 0);
    wait_to(e + 20);
    chk("t6_idle_run2", int'(running), 0);
    chk("t6_idle_snum", int'(s_num), 6);

    chk("snum_q_left", snum_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
